if_prefetch: RTL

//  Instruction-fetch initiator for the synchronous instruction ROM. Drives fetch PC
//  and request to the ROM, captures returned words one cycle later, buffers them with

---
 rtl/if_prefetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch initiator: issues sequential ROM requests under a credit limit,
// captures returned words into a small FIFO and presents them over valid/ready.
module if_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] rom_pc_o,
    output logic        rom_req_o,
    input  logic [31:0] rom_inst_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic [CW:0]   occupancy;

    // Buffered words plus the one still in the ROM pipeline must fit the FIFO.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue     = fetch_en_i & ~redirect_i & (occupancy < (CW+1)'(DEPTH));
    assign not_empty = (count_q != '0);
    assign push      = inflight_q & ~redirect_i;
    assign pop       = not_empty & inst_ready_i & ~redirect_i;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (issue) begin
            inflight_pc_d = pc_q;
        end

        if (redirect_i) begin
            pc_d     = redirect_pc_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + PC_STEP;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push) begin
            inst_mem_q[wr_ptr_q] <= rom_inst_i;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    assign rom_pc_o     = pc_q;
    assign rom_req_o    = issue;
    assign inst_valid_o = not_empty;
    assign inst_o       = not_empty ? inst_mem_q[rd_ptr_q] : '0;
    assign inst_pc_o    = not_empty ? pc_mem_q[rd_ptr_q]   : '0;

endmodule
